// File: rtl/pll_mode_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Module      : pll_mode_ctrl                                              |
// | Description : Video/system PLL sequencer. Pulses the PLL reset, programs |
// |               NTSC/PAL feedback and output dividers, qualifies the lock  |
// |               and holds the core reset until lock has been stable.       |
// | Option      : PLL_MODE_CTRL_LOCK_MON_EN - re-sequence on lock loss in    |
// |               RUN and expose a saturating lock_loss_cnt output.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pll_mode_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 65536,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned NTSC_MDIV    = 29,
    parameter int unsigned NTSC_ODIV    = 27,
    parameter int unsigned PAL_MDIV     = 33,
    parameter int unsigned PAL_ODIV     = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_req,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [6:0] pll_mdiv,
    output logic [6:0] pll_odiv,
    output logic       sys_reset,
    output logic       mode_cur,
    output logic       busy,
    output logic       error,
    output logic [1:0] retry_cnt
`ifdef PLL_MODE_CTRL_LOCK_MON_EN
    ,
    output logic [7:0] lock_loss_cnt
`else
`endif
);

    // Counter widths; a parameter of 1 still needs a 1-bit counter
    localparam int unsigned c_rst_w = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int unsigned c_stb_w = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
    localparam int unsigned c_to_w  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_stb_w-1:0] c_stb_last = c_stb_w'(LOCK_STABLE - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]         c_max_retry = 2'(MAX_RETRY);

    localparam logic [6:0] c_ntsc_mdiv = 7'(NTSC_MDIV);
    localparam logic [6:0] c_ntsc_odiv = 7'(NTSC_ODIV);
    localparam logic [6:0] c_pal_mdiv  = 7'(PAL_MDIV);
    localparam logic [6:0] c_pal_odiv  = 7'(PAL_ODIV);

    localparam logic [2:0] c_st_pll_rst   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_stable    = 3'd2;
    localparam logic [2:0] c_st_run       = 3'd3;
    localparam logic [2:0] c_st_fail      = 3'd4;

    logic [2:0]         r_state;
    logic [c_rst_w-1:0] r_rst_cnt;
    logic [c_stb_w-1:0] r_stb_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_lock_meta;
    logic               r_lock_s;
    logic               r_mode_meta;
    logic               r_mode_s;

    logic [1:0]         w_retry_inc;
    logic               w_go_rst;

    // Two-flop synchronizers for the asynchronous lock and the quasi-static mode request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_mode_meta <= 1'b0;
            r_mode_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_mode_meta <= mode_req;
            r_mode_s    <= r_mode_meta;
        end
    end

    assign w_retry_inc = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;

    // Every path that (re)enters PLL_RST, so entry actions live in one place
    always_comb begin
        w_go_rst = 1'b0;
        case (r_state)
            c_st_wait_lock: w_go_rst = !r_lock_s && (r_to_cnt == c_to_last) &&
                                       (w_retry_inc != c_max_retry);
            c_st_stable:    w_go_rst = r_lock_s && (r_stb_cnt == c_stb_last) &&
                                       (r_mode_s != mode_cur);
`ifdef PLL_MODE_CTRL_LOCK_MON_EN
            c_st_run:       w_go_rst = (r_mode_s != mode_cur) || !r_lock_s;
`else
            c_st_run:       w_go_rst = (r_mode_s != mode_cur);
`endif
            default:        w_go_rst = 1'b0;
        endcase
    end

    // Sequencer FSM; all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_pll_rst;
            r_rst_cnt <= '0;
            r_stb_cnt <= '0;
            r_to_cnt  <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            busy      <= 1'b1;
            error     <= 1'b0;
            retry_cnt <= 2'd0;
            mode_cur  <= 1'b0;
            pll_mdiv  <= c_ntsc_mdiv;
            pll_odiv  <= c_ntsc_odiv;
`ifdef PLL_MODE_CTRL_LOCK_MON_EN
            lock_loss_cnt <= 8'd0;
`endif
        end else if (w_go_rst) begin
            // Dividers only move here, while the PLL is being held in reset;
            // the latched mode covers both plain re-locks and mode changes
            r_state   <= c_st_pll_rst;
            r_rst_cnt <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            busy      <= 1'b1;
            mode_cur  <= r_mode_s;
            pll_mdiv  <= r_mode_s ? c_pal_mdiv : c_ntsc_mdiv;
            pll_odiv  <= r_mode_s ? c_pal_odiv : c_ntsc_odiv;
            if (r_state == c_st_wait_lock) begin
                retry_cnt <= w_retry_inc;
            end
`ifdef PLL_MODE_CTRL_LOCK_MON_EN
            if ((r_state == c_st_run) && !r_lock_s && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
`endif
        end else begin
            case (r_state)
                c_st_pll_rst: begin
                    if (r_rst_cnt == c_rst_last) begin
                        r_state   <= c_st_wait_lock;
                        r_to_cnt  <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                c_st_wait_lock: begin
                    if (r_lock_s) begin
                        r_state   <= c_st_stable;
                        r_stb_cnt <= '0;
                    end else if (r_to_cnt == c_to_last) begin
                        // Only the final allowed timeout falls through to here
                        r_state   <= c_st_fail;
                        retry_cnt <= w_retry_inc;
                        pll_reset <= 1'b1;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_st_stable: begin
                    if (!r_lock_s) begin
                        r_state  <= c_st_wait_lock;
                        r_to_cnt <= '0;
                    end else if (r_stb_cnt == c_stb_last) begin
                        // Mode mismatch at this point was taken by the re-entry path
                        r_state   <= c_st_run;
                        sys_reset <= 1'b0;
                        busy      <= 1'b0;
                        retry_cnt <= 2'd0;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                    end
                end
                c_st_run: begin
                    r_state <= c_st_run;
                end
                c_st_fail: begin
                    r_state <= c_st_fail;
                end
                default: begin
                    r_state   <= c_st_pll_rst;
                    r_rst_cnt <= '0;
                    pll_reset <= 1'b1;
                    sys_reset <= 1'b1;
                    busy      <= 1'b1;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
